// File: rtl/mem_responder_pkg.sv
// Shared transaction constants and types for the memory responder.
// Imported by the responder top and its gap controllers.
package mem_responder_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 16;
  localparam int REQUESTERS = 1;
  localparam int GAP_W      = 4;

  typedef enum logic {
    GS_READY = 1'b0,
    GS_GAP   = 1'b1
  } gap_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
  } type_uut;

endpackage

// File: rtl/mem_responder_gap_ctrl.sv
// Per-channel ready throttle: after each accept, ready drops for GAP
// cycles, then returns. GAP=0 keeps ready high once out of reset.
module responder_gap_ctrl #(
  parameter int GAP = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  output logic o_ready
);
  import mem_responder_pkg::*;

  localparam logic [GAP_W-1:0] GAP_L = GAP_W'(GAP);

  gap_state_e       r_state;
  gap_state_e       w_state_nxt;
  logic [GAP_W-1:0] r_cnt;
  logic [GAP_W-1:0] w_cnt_nxt;
  logic             r_live;
  logic             w_acc;

  assign w_acc = i_valid & o_ready;

  // state and countdown registers; r_live holds ready low during reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= GS_READY;
      r_cnt   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_live  <= 1'b1;
    end
  end

  // next state: enter GAP on accept, leave when the count hits 1
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      GS_READY: begin
        if (w_acc && (GAP_L != '0)) begin
          w_state_nxt = GS_GAP;
          w_cnt_nxt   = GAP_L;
        end
      end
      GS_GAP: begin
        if (r_cnt <= GAP_W'(1)) begin
          w_state_nxt = GS_READY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - GAP_W'(1);
        end
      end
    endcase
  end

  // ready output decode
  always_comb begin
    o_ready = r_live && (r_state == GS_READY);
  end

endmodule

// File: rtl/mem_responder.sv
// Single-port-per-direction memory responder with fixed read latency
// and independent write/read acceptance gaps.
module mem_responder #(
  parameter int DATA_WIDTH = mem_responder_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = mem_responder_pkg::ADDR_WIDTH,
  parameter int MEM_AW     = 8,
  parameter int RD_LATENCY = 2,
  parameter int WR_GAP     = 1,
  parameter int RD_GAP     = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic                  r_avalid,
  output logic                  r_aready,
  output logic                  r_dvalid,
  output logic [DATA_WIDTH-1:0] r_data
);
  import mem_responder_pkg::*;

  localparam int DEPTH = 1 << MEM_AW;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dat [RD_LATENCY];
  logic [RD_LATENCY-1:0] r_vld;
  logic                  w_wacc;
  logic                  w_racc;
  logic [MEM_AW-1:0]     w_widx;
  logic [MEM_AW-1:0]     w_ridx;
  logic                  w_unused_addr;

  assign w_wacc = w_valid & w_ready;
  assign w_racc = r_avalid & r_aready;
  assign w_widx = w_addr[MEM_AW-1:0];
  assign w_ridx = r_addr[MEM_AW-1:0];

  assign w_unused_addr = ^{w_addr[ADDR_WIDTH-1:MEM_AW],
                           r_addr[ADDR_WIDTH-1:MEM_AW]};

  responder_gap_ctrl #(
    .GAP(WR_GAP)
  ) u_wgap (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_valid(w_valid),
    .o_ready(w_ready)
  );

  responder_gap_ctrl #(
    .GAP(RD_GAP)
  ) u_rgap (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_valid(r_avalid),
    .o_ready(r_aready)
  );

  // memory write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_wacc) begin
      r_mem[w_widx] <= w_data;
    end
  end

  // read pipeline: stage 0 samples the pre-write word (read-first)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_racc;
      r_dat[0] <= w_racc ? r_mem[w_ridx] : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign r_dvalid = r_vld[RD_LATENCY-1];
  assign r_data   = r_vld[RD_LATENCY-1] ? r_dat[RD_LATENCY-1] : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a
// queue-based reference model of the read/write behaviour.
module tb_mem_responder;

  localparam int L  = 2;
  localparam int WG = 3;
  localparam int RG = 0;

  logic        clk;
  logic        reset_n;
  logic [15:0] w_addr;
  logic [15:0] w_data;
  logic        w_valid;
  logic        w_ready;
  logic [15:0] r_addr;
  logic        r_avalid;
  logic        r_aready;
  logic        r_dvalid;
  logic [15:0] r_data;

  int n_pass;
  int n_total;

  typedef struct {
    int          due;
    logic [15:0] d;
  } rd_t;

  rd_t         q[$];
  logic [15:0] m_mem [256];
  int          m_wwait;
  int          m_rwait;
  int          edge_n;
  logic        m_wacc;
  logic        m_racc;
  logic        e_wready;
  logic        e_raready;
  logic        e_dvalid;
  logic [15:0] e_rdata;

  mem_responder #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(16),
    .MEM_AW    (8),
    .RD_LATENCY(L),
    .WR_GAP    (WG),
    .RD_GAP    (RG)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .w_valid (w_valid),
    .w_ready (w_ready),
    .r_addr  (r_addr),
    .r_avalid(r_avalid),
    .r_aready(r_aready),
    .r_dvalid(r_dvalid),
    .r_data  (r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset_n === 1'b1) begin
      assert (!$isunknown({w_valid, r_avalid}))
      else $error("protocol: X on request valid");
    end
  end

  task automatic model_reset();
    q.delete();
    m_wwait   = 0;
    m_rwait   = 0;
    e_wready  = 1'b0;
    e_raready = 1'b0;
    e_dvalid  = 1'b0;
    e_rdata   = '0;
  endtask

  // drive one cycle at negedge, advance model at posedge, return at negedge
  task automatic tick(input logic wv, input logic [15:0] wa,
                      input logic [15:0] wd, input logic rv,
                      input logic [15:0] ra);
    rd_t it;
    w_valid  = wv;
    w_addr   = wa;
    w_data   = wd;
    r_avalid = rv;
    r_addr   = ra;
    @(posedge clk);
    edge_n++;
    m_wacc = wv && e_wready;
    m_racc = rv && e_raready;
    if (m_racc) begin
      it.due = edge_n + L - 1;
      it.d   = m_mem[ra[7:0]];
      q.push_back(it);
    end
    if (m_wacc) m_mem[wa[7:0]] = wd;
    if (m_wacc) m_wwait = WG;
    else if (m_wwait > 0) m_wwait--;
    if (m_racc) m_rwait = RG;
    else if (m_rwait > 0) m_rwait--;
    e_wready  = (m_wwait == 0);
    e_raready = (m_rwait == 0);
    e_dvalid  = 1'b0;
    e_rdata   = '0;
    if (q.size() > 0 && q[0].due == edge_n) begin
      e_dvalid = 1'b1;
      e_rdata  = q[0].d;
      void'(q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    w_valid  = 1'b0;
    r_avalid = 1'b0;
    w_addr   = '0;
    w_data   = '0;
    r_addr   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (w_ready !== 1'b0) $display("FAIL rst_wready got %b want 0", w_ready);
    else n_pass++;
    n_total++;
    if (r_aready !== 1'b0) $display("FAIL rst_raready got %b want 0", r_aready);
    else n_pass++;
    n_total++;
    if (r_dvalid !== 1'b0) $display("FAIL rst_dvalid got %b want 0", r_dvalid);
    else n_pass++;
    n_total++;
    if (r_data !== 16'h0) $display("FAIL rst_rdata got %h want 0000", r_data);
    else n_pass++;
    reset_n = 1'b1;
    tick(1'b0, '0, '0, 1'b0, '0);
    n_total++;
    if (w_ready !== 1'b1) $display("FAIL rel_wready got %b want 1", w_ready);
    else n_pass++;
    n_total++;
    if (r_aready !== 1'b1) $display("FAIL rel_raready got %b want 1", r_aready);
    else n_pass++;
  endtask

  task automatic test_prefill();
    logic ok;
    for (int a = 0; a < 256; a++) begin
      ok = 1'b0;
      for (int t = 0; t < WG + 2 && !ok; t++) begin
        tick(1'b1, 16'(a), 16'($urandom), 1'b0, '0);
        ok = m_wacc;
      end
      n_total++;
      if (w_ready !== e_wready)
        $display("FAIL fill_wready a=%0d got %b want %b", a, w_ready, e_wready);
      else n_pass++;
    end
    idle(WG + 1);
  endtask

  task automatic test_basic();
    idle(WG + 1);
    tick(1'b1, 16'h0010, 16'hBEEF, 1'b0, '0);
    tick(1'b0, '0, '0, 1'b1, 16'h0010);
    n_total++;
    if (r_dvalid !== 1'b0) $display("FAIL basic_early got %b want 0", r_dvalid);
    else n_pass++;
    tick(1'b0, '0, '0, 1'b0, '0);
    n_total++;
    if (r_dvalid !== 1'b1 || r_data !== 16'hBEEF)
      $display("FAIL basic_data got %b/%h want 1/beef", r_dvalid, r_data);
    else n_pass++;
    tick(1'b0, '0, '0, 1'b0, '0);
    n_total++;
    if (r_dvalid !== 1'b0 || r_data !== 16'h0)
      $display("FAIL basic_after got %b/%h want 0/0000", r_dvalid, r_data);
    else n_pass++;
  endtask

  task automatic test_wrap();
    idle(WG + 1);
    tick(1'b1, 16'h0105, 16'h1234, 1'b0, '0);
    tick(1'b0, '0, '0, 1'b1, 16'h0005);
    tick(1'b0, '0, '0, 1'b0, '0);
    n_total++;
    if (r_dvalid !== 1'b1 || r_data !== 16'h1234)
      $display("FAIL wrap got %b/%h want 1/1234", r_dvalid, r_data);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d;
    for (int i = 1; i <= 3; i++) begin
      idle(WG + 1);
      tick(1'b1, 16'(i), 16'(16'hA0 + i), 1'b0, '0);
    end
    idle(WG + 1);
    for (int i = 1; i <= 4; i++) begin
      tick(1'b0, '0, '0, (i <= 3), 16'(i));
      if (i >= 2) begin
        exp_d = 16'(16'hA0 + i - 1);
        n_total++;
        if (r_dvalid !== 1'b1 || r_data !== exp_d)
          $display("FAIL b2b_%0d got %b/%h want 1/%h", i - 1, r_dvalid, r_data, exp_d);
        else n_pass++;
      end
    end
    tick(1'b0, '0, '0, 1'b0, '0);
    n_total++;
    if (r_dvalid !== 1'b0) $display("FAIL b2b_end got %b want 0", r_dvalid);
    else n_pass++;
  endtask

  task automatic test_wr_gap();
    logic [7:0]  pat;
    int          nacc;
    logic [15:0] exp_d;
    pat  = 8'b1000_1000;
    nacc = 0;
    idle(WG + 1);
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (w_ready !== pat[7-i])
        $display("FAIL gap_pat_%0d got %b want %b", i, w_ready, pat[7-i]);
      else n_pass++;
      if (w_ready === 1'b1) nacc++;
      tick(1'b1, 16'(16'h0040 + i), 16'(16'h7000 + i), 1'b0, '0);
    end
    n_total++;
    if (nacc !== 2) $display("FAIL gap_count got %0d want 2", nacc);
    else n_pass++;
    idle(WG + 1);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, '0, '0, 1'b1, 16'(16'h0040 + i));
      tick(1'b0, '0, '0, 1'b0, '0);
      n_total++;
      if (r_dvalid !== 1'b1 || r_data !== e_rdata)
        $display("FAIL gap_rd_%0d got %b/%h want 1/%h", i, r_dvalid, r_data, e_rdata);
      else n_pass++;
      if (i == 0 || i == 4) begin
        exp_d = 16'(16'h7000 + i);
        n_total++;
        if (r_data !== exp_d)
          $display("FAIL gap_word_%0d got %h want %h", i, r_data, exp_d);
        else n_pass++;
      end
    end
  endtask

  task automatic test_same_edge();
    idle(WG + 1);
    tick(1'b1, 16'h0020, 16'hAAAA, 1'b0, '0);
    idle(WG);
    tick(1'b1, 16'h0020, 16'h5555, 1'b1, 16'h0020);
    tick(1'b0, '0, '0, 1'b0, '0);
    n_total++;
    if (r_dvalid !== 1'b1 || r_data !== 16'hAAAA)
      $display("FAIL same_old got %b/%h want 1/aaaa", r_dvalid, r_data);
    else n_pass++;
    tick(1'b0, '0, '0, 1'b1, 16'h0020);
    tick(1'b0, '0, '0, 1'b0, '0);
    n_total++;
    if (r_dvalid !== 1'b1 || r_data !== 16'h5555)
      $display("FAIL same_new got %b/%h want 1/5555", r_dvalid, r_data);
    else n_pass++;
  endtask

  task automatic test_inflight();
    logic [15:0] old;
    idle(WG + 1);
    old = m_mem[8'h30] ^ 16'h0F0F;
    tick(1'b1, 16'h0030, old, 1'b0, '0);
    idle(WG);
    tick(1'b0, '0, '0, 1'b1, 16'h0030);
    tick(1'b1, 16'h0030, ~old, 1'b0, '0);
    n_total++;
    if (r_dvalid !== 1'b1 || r_data !== old)
      $display("FAIL inflight got %b/%h want 1/%h", r_dvalid, r_data, old);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      tick(1'($urandom), 16'($urandom), 16'($urandom),
           1'($urandom), 16'($urandom));
      n_total++;
      if (w_ready !== e_wready)
        $display("FAIL rnd_wready t=%0d got %b want %b", t, w_ready, e_wready);
      else n_pass++;
      n_total++;
      if (r_aready !== e_raready)
        $display("FAIL rnd_raready t=%0d got %b want %b", t, r_aready, e_raready);
      else n_pass++;
      n_total++;
      if (r_dvalid !== e_dvalid || r_data !== e_rdata)
        $display("FAIL rnd_rdata t=%0d got %b/%h want %b/%h",
                 t, r_dvalid, r_data, e_dvalid, e_rdata);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midflight();
    idle(WG + 1);
    tick(1'b0, '0, '0, 1'b1, 16'h0010);
    reset_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (r_dvalid !== 1'b0 || w_ready !== 1'b0 || r_aready !== 1'b0)
      $display("FAIL mid_assert got %b%b%b want 000", r_dvalid, w_ready, r_aready);
    else n_pass++;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    n_total++;
    if (r_dvalid !== 1'b0) $display("FAIL mid_hold got %b want 0", r_dvalid);
    else n_pass++;
    w_valid  = 1'b0;
    r_avalid = 1'b0;
    reset_n  = 1'b1;
    tick(1'b0, '0, '0, 1'b0, '0);
    n_total++;
    if (w_ready !== 1'b1 || r_aready !== 1'b1)
      $display("FAIL mid_release got %b%b want 11", w_ready, r_aready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (r_dvalid !== 1'b0) $display("FAIL mid_drop_%0d got %b want 0", i, r_dvalid);
      else n_pass++;
      tick(1'b0, '0, '0, 1'b0, '0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    edge_n  = 0;
    test_reset();
    test_prefill();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_wr_gap();
    test_same_edge();
    test_inflight();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
